// File: rtl/stage4_mem.sv
// Memory-access pipeline stage: issues loads/stores to data memory over a
// req/ready handshake, extends load data, and stalls upstream while a request is open.
module stage4_mem (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] alu_res,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd_idx,
  input  logic [2:0]  funct3,
  input  logic        mem_read_enable,
  input  logic        mem_write_enable,
  input  logic        reg_write_enable,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wb_val_out,
  output logic [4:0]  rd_idx_out,
  output logic        reg_write_enable_out,
  output logic        mem_fault_out,
  output logic [31:0] fault_addr_out
);

  // Handshake: dmem_req rises the cycle after an op is captured and stays high,
  // with dmem_we/addr/wdata/wstrb frozen, up to and including the cycle in which
  // dmem_ready is sampled high; dmem_ready outside an open request is ignored.
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state, state_next;
  logic        is_mem, illegal, misaligned, fault, start;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        rwe_q;
  logic [31:0] lane, load_val;

  always_comb begin
    is_mem     = mem_read_enable | mem_write_enable;
    illegal    = mem_read_enable & mem_write_enable;
    misaligned = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: ;
      3'b100, 3'b101:         illegal = illegal | mem_write_enable;
      default:                illegal = 1'b1;
    endcase
    case (funct3[1:0])
      2'b01:   misaligned = alu_res[0];
      2'b10:   misaligned = |alu_res[1:0];
      default: misaligned = 1'b0;
    endcase
    fault = is_mem & (illegal | misaligned);
    start = is_mem & ~fault;
    case (funct3[1:0])
      2'b00: begin
        wstrb_c = 4'b0001 << alu_res[1:0];
        wdata_c = {4{rs2_val[7:0]}};
      end
      2'b01: begin
        wstrb_c = 4'b0011 << alu_res[1:0];
        wdata_c = {2{rs2_val[15:0]}};
      end
      default: begin
        wstrb_c = 4'b1111;
        wdata_c = rs2_val;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = REQ;
      REQ:  if (dmem_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  assign dmem_req  = (state == REQ);
  assign stall_out = (state == REQ);

  // Shift the addressed lane down to bit 0, then extend per access size/sign.
  always_comb begin
    lane = dmem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_val = {24'h0, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_val = {16'h0, lane[15:0]};
      default: load_val = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dmem_we              <= 1'b0;
      dmem_addr            <= '0;
      dmem_wdata           <= '0;
      dmem_wstrb           <= '0;
      wb_val_out           <= '0;
      rd_idx_out           <= '0;
      reg_write_enable_out <= 1'b0;
      mem_fault_out        <= 1'b0;
      fault_addr_out       <= '0;
      f3_q                 <= '0;
      off_q                <= '0;
      rd_q                 <= '0;
      rwe_q                <= 1'b0;
    end else begin
      mem_fault_out <= 1'b0;
      case (state)
        IDLE: begin
          if (fault) begin
            mem_fault_out        <= 1'b1;
            fault_addr_out       <= alu_res;
            reg_write_enable_out <= 1'b0;
          end else if (start) begin
            dmem_we              <= mem_write_enable;
            dmem_addr            <= {alu_res[31:2], 2'b00};
            dmem_wdata           <= wdata_c;
            dmem_wstrb           <= mem_write_enable ? wstrb_c : 4'b0000;
            f3_q                 <= funct3;
            off_q                <= alu_res[1:0];
            rd_q                 <= rd_idx;
            rwe_q                <= reg_write_enable;
            reg_write_enable_out <= 1'b0;
          end else begin
            wb_val_out           <= alu_res;
            rd_idx_out           <= rd_idx;
            reg_write_enable_out <= reg_write_enable;
          end
        end
        REQ: begin
          if (dmem_ready) begin
            if (!dmem_we) begin
              wb_val_out           <= load_val;
              rd_idx_out           <= rd_q;
              reg_write_enable_out <= rwe_q;
            end else begin
              reg_write_enable_out <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage4_mem.sv
// Self-checking bench for stage4_mem: directed literal cases plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_stage4_mem;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] alu_res = '0;
  logic [31:0] rs2_val = '0;
  logic [4:0]  rd_idx = '0;
  logic [2:0]  funct3 = '0;
  logic        mem_read_enable = 1'b0;
  logic        mem_write_enable = 1'b0;
  logic        reg_write_enable = 1'b0;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] wb_val_out, fault_addr_out;
  logic [4:0]  rd_idx_out;
  logic        reg_write_enable_out, mem_fault_out;

  always #5 clk = ~clk;

  stage4_mem dut (
    .clk(clk), .reset_n(reset_n), .alu_res(alu_res), .rs2_val(rs2_val),
    .rd_idx(rd_idx), .funct3(funct3), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .reg_write_enable(reg_write_enable),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .wb_val_out(wb_val_out),
    .rd_idx_out(rd_idx_out), .reg_write_enable_out(reg_write_enable_out),
    .mem_fault_out(mem_fault_out), .fault_addr_out(fault_addr_out)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic int f_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit f_fault(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a);
    int s;
    s = f_size(f3);
    if (rd && wr) return 1'b1;
    if (s == 0) return 1'b1;
    if (wr && f3[2]) return 1'b1;
    return (int'(a[1:0]) % s) != 0;
  endfunction

  function automatic logic [3:0] f_wstrb(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] r;
    int s, off;
    s = f_size(f3);
    off = int'(a[1:0]);
    r = '0;
    for (int b = 0; b < 4; b++) r[b] = (b >= off) && (b < off + s);
    return r;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int s;
    s = f_size(f3);
    r = '0;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = d[8*(b % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] word);
    longint v;
    int s, off;
    s = f_size(f3);
    off = int'(a[1:0]);
    v = longint'({32'h0, word}) >> (8 * off);
    v = v & ((64'sd1 <<< (8 * s)) - 1);
    if (!f3[2] && s < 4 && v >= (64'sd1 <<< (8 * s - 1))) v = v - (64'sd1 <<< (8 * s));
    return v[31:0];
  endfunction

  logic        exp_stall = 0, exp_req = 0, exp_we = 0, exp_rwe = 0, exp_fault = 0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_wb = '0, exp_faddr = '0;
  logic [3:0]  exp_wstrb = '0;
  logic [4:0]  exp_rd = '0;
  bit          pend = 0, p_load = 0, p_rwe = 0;
  logic [2:0]  p_f3 = '0;
  logic [31:0] p_addr = '0;
  logic [4:0]  p_rd = '0;

  always @(posedge clk) begin
    if (!reset_n) begin
      pend <= 0; exp_stall <= 0; exp_req <= 0; exp_we <= 0; exp_rwe <= 0; exp_fault <= 0;
      exp_addr <= '0; exp_wdata <= '0; exp_wstrb <= '0; exp_wb <= '0; exp_rd <= '0;
      exp_faddr <= '0;
    end else if (pend) begin
      exp_fault <= 0;
      if (dmem_ready) begin
        pend <= 0; exp_req <= 0; exp_stall <= 0;
        if (p_load) begin
          exp_wb  <= f_load(p_f3, p_addr, dmem_rdata);
          exp_rd  <= p_rd;
          exp_rwe <= p_rwe;
        end else begin
          exp_rwe <= 0;
        end
      end
    end else begin
      exp_fault <= 0;
      if (!(mem_read_enable || mem_write_enable)) begin
        exp_wb <= alu_res; exp_rd <= rd_idx; exp_rwe <= reg_write_enable;
      end else if (f_fault(mem_read_enable, mem_write_enable, funct3, alu_res)) begin
        exp_fault <= 1; exp_faddr <= alu_res; exp_rwe <= 0;
      end else begin
        pend <= 1; exp_req <= 1; exp_stall <= 1; exp_rwe <= 0;
        exp_we    <= mem_write_enable;
        exp_addr  <= alu_res & ~32'h3;
        exp_wstrb <= mem_write_enable ? f_wstrb(funct3, alu_res) : 4'b0000;
        exp_wdata <= f_wdata(funct3, rs2_val);
        p_load <= mem_read_enable; p_f3 <= funct3; p_addr <= alu_res;
        p_rd <= rd_idx; p_rwe <= reg_write_enable;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("stall_out", stall_out, exp_stall);
      chk("dmem_req", dmem_req, exp_req);
      chk("mem_fault_out", mem_fault_out, exp_fault);
      chk("reg_write_enable_out", reg_write_enable_out, exp_rwe);
      if (exp_req) begin
        chk("dmem_we", dmem_we, exp_we);
        chk("dmem_addr", dmem_addr, exp_addr);
        chk("dmem_wstrb", dmem_wstrb, exp_wstrb);
        if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
      end
      if (exp_rwe) begin
        chk("wb_val_out", wb_val_out, exp_wb);
        chk("rd_idx_out", rd_idx_out, exp_rd);
      end
      if (exp_fault) chk("fault_addr_out", fault_addr_out, exp_faddr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                           input logic rd, input logic wr, input logic [4:0] r,
                           input logic rwe);
    alu_res = a; rs2_val = d; funct3 = f3; mem_read_enable = rd;
    mem_write_enable = wr; rd_idx = r; reg_write_enable = rwe;
  endtask

  task automatic idle();
    set_instr(32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  logic [2:0] f3_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  task automatic rand_instr();
    int kind;
    logic [31:0] a;
    logic [2:0] f3;
    kind = $urandom_range(0, 9);
    a = $urandom;
    if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
    f3 = ($urandom_range(0, 9) < 8) ? f3_tab[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
    set_instr(a, $urandom, f3, kind inside {[4:6], 9}, kind inside {[7:9]},
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int stalls;
    bit st;
    reset_n = 0;
    idle();
    step(); step();
    check_en = 1;
    chk("rst_stall", stall_out, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wstrb", dmem_wstrb, 0);
    chk("rst_wb", wb_val_out, 0);
    chk("rst_rd", rd_idx_out, 0);
    chk("rst_rwe", reg_write_enable_out, 0);
    chk("rst_fault", mem_fault_out, 0);
    chk("rst_faddr", fault_addr_out, 0);
    reset_n = 1;

    // ADD
    set_instr(32'h1234, 32'h0, 3'b000, 0, 0, 5'd5, 1);
    step();
    chk("add_wb", wb_val_out, 32'h1234);
    chk("add_rd", rd_idx_out, 5);
    chk("add_rwe", reg_write_enable_out, 1);
    chk("add_stall", stall_out, 0);
    idle(); step();

    // LB / LBU at 0x103, ready in the third stall cycle
    for (int u = 0; u < 2; u++) begin
      set_instr(32'h103, 32'h0, (u == 0) ? 3'b000 : 3'b100, 1, 0, 5'd7, 1);
      dmem_ready = 0; dmem_rdata = 32'h80AABBCC;
      step();
      chk("lb_req", dmem_req, 1);
      chk("lb_addr", dmem_addr, 32'h100);
      chk("lb_wstrb", dmem_wstrb, 0);
      chk("lb_bubble", reg_write_enable_out, 0);
      idle();
      stalls = 0;
      for (int c = 0; c < 3; c++) begin
        if (stall_out) stalls++;
        if (c == 2) dmem_ready = 1;
        step();
      end
      dmem_ready = 0;
      chk("lb_stall_cycles", stalls, 3);
      chk("lb_stall_low", stall_out, 0);
      chk("lb_wb", wb_val_out, (u == 0) ? 32'hFFFFFF80 : 32'h00000080);
      chk("lb_rd", rd_idx_out, 7);
      chk("lb_rwe", reg_write_enable_out, 1);
      step();
    end

    // SH at 0x202, ready immediately
    set_instr(32'h202, 32'hDEADBEEF, 3'b001, 0, 1, 5'd9, 1);
    dmem_ready = 1;
    step();
    idle();
    chk("sh_req", dmem_req, 1);
    chk("sh_we", dmem_we, 1);
    chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    chk("sh_wstrb", dmem_wstrb, 4'b1100);
    step();
    dmem_ready = 0;
    chk("sh_done_stall", stall_out, 0);
    chk("sh_rwe", reg_write_enable_out, 0);
    step();

    // Misaligned LW and read+write faults
    set_instr(32'h101, 32'h0, 3'b010, 1, 0, 5'd3, 1);
    step();
    idle();
    chk("lw_mis_fault", mem_fault_out, 1);
    chk("lw_mis_faddr", fault_addr_out, 32'h101);
    chk("lw_mis_req", dmem_req, 0);
    chk("lw_mis_stall", stall_out, 0);
    step();
    chk("lw_mis_pulse_end", mem_fault_out, 0);
    set_instr(32'h40, 32'h0, 3'b010, 1, 1, 5'd3, 1);
    step();
    idle();
    chk("rw_fault", mem_fault_out, 1);
    chk("rw_faddr", fault_addr_out, 32'h40);
    step();

    // Reset in the middle of a request
    set_instr(32'h10, 32'h0, 3'b010, 1, 0, 5'd4, 1);
    dmem_ready = 0;
    step();
    idle();
    chk("mid_req", dmem_req, 1);
    reset_n = 0;
    step();
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_stall", stall_out, 0);
    chk("mid_rst_wb", wb_val_out, 0);
    chk("mid_rst_addr", dmem_addr, 0);
    reset_n = 1;
    set_instr(32'h55, 32'h0, 3'b000, 0, 0, 5'd3, 1);
    step();
    chk("post_rst_add_wb", wb_val_out, 32'h55);
    chk("post_rst_add_rd", rd_idx_out, 3);
    idle(); step();

    // Back-to-back LWs at 0x0 and 0x4
    set_instr(32'h0, 32'h0, 3'b010, 1, 0, 5'd1, 1);
    dmem_ready = 1; dmem_rdata = 32'h11111111;
    step();
    chk("b2b_req0", dmem_req, 1);
    chk("b2b_addr0", dmem_addr, 32'h0);
    set_instr(32'h4, 32'h0, 3'b010, 1, 0, 5'd2, 1);
    step();
    chk("b2b_gap_req", dmem_req, 0);
    chk("b2b_wb0", wb_val_out, 32'h11111111);
    chk("b2b_rd0", rd_idx_out, 1);
    dmem_rdata = 32'h22222222;
    step();
    idle();
    chk("b2b_req1", dmem_req, 1);
    chk("b2b_addr1", dmem_addr, 32'h4);
    step();
    dmem_ready = 0;
    chk("b2b_wb1", wb_val_out, 32'h22222222);
    chk("b2b_rd1", rd_idx_out, 2);

    // Randomized traffic; upstream only advances when the stage did not stall
    for (int i = 0; i < 3000; i++) begin
      st = exp_stall;
      step();
      if (!st) rand_instr();
      dmem_ready = ($urandom_range(0, 2) == 0);
      dmem_rdata = $urandom;
      reset_n = ($urandom_range(0, 199) != 0);
    end
    reset_n = 1;
    idle();
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
